// File: rtl/gprf_pkg.sv
// Shared types and constants for the GPR file with pending-write scoreboard.
package gprf_pkg;

   localparam int unsigned GPRF_DEPTH = 32;
   localparam int unsigned GPRF_WIDTH = 32;

   typedef enum logic {
      GPRF_INIT,
      GPRF_RUN
   } gprf_state_e;

   // True when an index addresses a real, writable register.
   function automatic logic gprf_idx_live(input int unsigned idx,
                                          input int unsigned depth,
                                          input logic        r0_is_0);
      return (idx < depth) && !(r0_is_0 && (idx == 0));
   endfunction

endpackage

// File: rtl/gprf_scoreboard.sv
// Per-register pending bits: one reserve port, NWPORTS clear ports, NRPORTS busy lookups.
module gprf_scoreboard
   import gprf_pkg::*;
#(
   parameter int unsigned NRPORTS = 2,
   parameter int unsigned NWPORTS = 1,
   parameter int unsigned DEPTH   = GPRF_DEPTH,
   parameter bit          R0_IS_0 = 1'b0,
   localparam int unsigned IW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rsv_en,
   input  logic [IW-1:0]      rsv_idx,
   input  logic [NWPORTS-1:0] clr_en,
   input  logic [IW-1:0]      clr_idx [NWPORTS],
   input  logic [IW-1:0]      lk_idx [NRPORTS],
   output logic               lk_busy_c [NRPORTS],
   output logic               rsv_conflict_c
);

   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;
   logic             rsv_live;
   logic             clr_hit;

   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   // Clears first, then the reserve, so a same-cycle reserve keeps the register pending.
   always_comb begin
      pend_d   = pend_q;
      clr_hit  = 1'b0;
      rsv_live = rsv_en && gprf_idx_live(32'(rsv_idx), DEPTH, R0_IS_0);
      for (int unsigned wp = 0; wp < NWPORTS; wp++) begin
         if (clr_en[wp] && gprf_idx_live(32'(clr_idx[wp]), DEPTH, R0_IS_0)) begin
            pend_d[clr_idx[wp]] = 1'b0;
            if (clr_idx[wp] == rsv_idx) clr_hit = 1'b1;
         end
      end
      if (rsv_live) pend_d[rsv_idx] = 1'b1;
      if (R0_IS_0)  pend_d[0] = 1'b0;
      rsv_conflict_c = rsv_live && pend_q[rsv_idx] && !clr_hit;
   end

   always_comb begin
      for (int unsigned rp = 0; rp < NRPORTS; rp++) begin
         lk_busy_c[rp] = gprf_idx_live(32'(lk_idx[rp]), DEPTH, R0_IS_0) && pend_q[lk_idx[rp]];
      end
   end

endmodule

// File: rtl/gprf_sb.sv
// GPR file with pending-write scoreboard and zero-init sweep after reset.
// Optional same-cycle write-to-read bypass enabled by defining GPRF_SB_BYPASS_EN.
module gprf_sb
   import gprf_pkg::*;
#(
   parameter int unsigned NRPORTS = 2,
   parameter int unsigned NWPORTS = 1,
   parameter int unsigned DEPTH   = GPRF_DEPTH,
   parameter int unsigned WIDTH   = GPRF_WIDTH,
   parameter bit          R0_IS_0 = 1'b0,
   localparam int unsigned IW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
   input  logic [IW-1:0]    ridx [NRPORTS],
   output logic [WIDTH-1:0] rdata [NRPORTS],
   output logic             rbusy [NRPORTS],
   input  logic             rsv_en,
   input  logic [IW-1:0]    rsv_idx,
   output logic             rsv_conflict,
   input  logic             wen [NWPORTS],
   input  logic [IW-1:0]    widx [NWPORTS],
   input  logic [WIDTH-1:0] wdata [NWPORTS]
);

   gprf_state_e        state_q, state_d;
   logic [IW-1:0]      cnt_q, cnt_d;
   logic               run;
   logic [NWPORTS-1:0] wr_live;
   logic               sb_busy [NRPORTS];
   logic               sb_conflict;
   logic [WIDTH-1:0]   mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GPRF_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         GPRF_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(DEPTH - 1)) state_d = GPRF_RUN;
         end
         GPRF_RUN: ;
         default:  state_d = GPRF_INIT;
      endcase
   end

   assign run   = (state_q == GPRF_RUN);
   assign ready = run;

   always_comb begin
      for (int unsigned wp = 0; wp < NWPORTS; wp++) begin
         wr_live[wp] = run && wen[wp] && gprf_idx_live(32'(widx[wp]), DEPTH, R0_IS_0);
      end
   end

   // Ascending port order: the highest-numbered writer lands last.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[cnt_q] <= '0;
      end else begin
         for (int unsigned wp = 0; wp < NWPORTS; wp++) begin
            if (wr_live[wp]) mem[widx[wp]] <= wdata[wp];
         end
      end
   end

   gprf_scoreboard #(
      .NRPORTS (NRPORTS),
      .NWPORTS (NWPORTS),
      .DEPTH   (DEPTH),
      .R0_IS_0 (R0_IS_0)
   ) u_sb (
      .clk            (clk),
      .rst            (rst),
      .rsv_en         (run && rsv_en),
      .rsv_idx        (rsv_idx),
      .clr_en         (wr_live),
      .clr_idx        (widx),
      .lk_idx         (ridx),
      .lk_busy_c      (sb_busy),
      .rsv_conflict_c (sb_conflict)
   );

   assign rsv_conflict = sb_conflict;

   always_comb begin
      for (int unsigned rp = 0; rp < NRPORTS; rp++) begin
         rdata[rp] = '0;
         rbusy[rp] = 1'b0;
         if (run && gprf_idx_live(32'(ridx[rp]), DEPTH, R0_IS_0)) begin
            rdata[rp] = mem[ridx[rp]];
            rbusy[rp] = sb_busy[rp];
         end
`ifdef GPRF_SB_BYPASS_EN
         for (int unsigned wp = 0; wp < NWPORTS; wp++) begin
            if (wr_live[wp] && (widx[wp] == ridx[rp])) begin
               rdata[rp] = wdata[wp];
               rbusy[rp] = 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_gprf_sb.sv
// Directed bench for gprf_sb: expected values queued at stimulus, popped at sampling.
module tb_gprf_sb;

`ifdef GPRF_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: DEPTH 32, two write ports, r0 hardwired to zero
   logic        a_ready;
   logic [4:0]  a_ridx [2];
   logic [31:0] a_rdata [2];
   logic        a_rbusy [2];
   logic        a_rsv_en;
   logic [4:0]  a_rsv_idx;
   logic        a_rsv_conflict;
   logic        a_wen [2];
   logic [4:0]  a_widx [2];
   logic [31:0] a_wdata [2];

   // Instance B: DEPTH 20 (non power of two), one write port, r0 ordinary
   logic        b_ready;
   logic [4:0]  b_ridx [2];
   logic [31:0] b_rdata [2];
   logic        b_rbusy [2];
   logic        b_rsv_en;
   logic [4:0]  b_rsv_idx;
   logic        b_rsv_conflict;
   logic        b_wen [1];
   logic [4:0]  b_widx [1];
   logic [31:0] b_wdata [1];

   gprf_sb #(.NRPORTS(2), .NWPORTS(2), .DEPTH(32), .WIDTH(32), .R0_IS_0(1'b1)) u_a (
      .clk(clk), .rst(rst), .ready(a_ready), .ridx(a_ridx), .rdata(a_rdata), .rbusy(a_rbusy),
      .rsv_en(a_rsv_en), .rsv_idx(a_rsv_idx), .rsv_conflict(a_rsv_conflict),
      .wen(a_wen), .widx(a_widx), .wdata(a_wdata));

   gprf_sb #(.NRPORTS(2), .NWPORTS(1), .DEPTH(20), .WIDTH(32), .R0_IS_0(1'b0)) u_b (
      .clk(clk), .rst(rst), .ready(b_ready), .ridx(b_ridx), .rdata(b_rdata), .rbusy(b_rbusy),
      .rsv_en(b_rsv_en), .rsv_idx(b_rsv_idx), .rsv_conflict(b_rsv_conflict),
      .wen(b_wen), .widx(b_widx), .wdata(b_wdata));

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   la, lb;

   task automatic push(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sbq.push_back(x);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t x;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         x = sbq.pop_front();
         assert (obs === x.exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         a_ridx[i] = '0; a_wen[i] = 1'b0; a_widx[i] = '0; a_wdata[i] = '0;
         b_ridx[i] = '0;
      end
      a_rsv_en = 1'b0; a_rsv_idx = '0;
      b_rsv_en = 1'b0; b_rsv_idx = '0;
      b_wen[0] = 1'b0; b_widx[0] = '0; b_wdata[0] = '0;
   endtask

   // Count edges after reset release until each instance reports ready (bounded).
   task automatic sweep(input bit rsv_during);
      la = 0;
      lb = 0;
      for (int c = 1; c <= 80 && (la == 0 || lb == 0); c++) begin
         a_rsv_en  = rsv_during && (c <= 3);
         a_rsv_idx = 5'd10;
         tick();
         if (a_ready && la == 0) la = c;
         if (b_ready && lb == 0) lb = c;
      end
      a_rsv_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) tick();

      push("rst_ready", 0);     chk(32'(a_ready));
      push("rst_rbusy", 0);     chk(32'(a_rbusy[0]));
      push("rst_conflict", 0);  chk(32'(a_rsv_conflict));
      push("rst_rdata", 0);     chk(a_rdata[0]);

      rst = 1'b0;
      push("ready_lat_a", 32);
      push("ready_lat_b", 20);
      sweep(1'b0);
      chk(32'(la));
      chk(32'(lb));

      // Preload r5, then reset and confirm the sweep clears it
      a_wen[0] = 1'b1; a_widx[0] = 5'd5; a_wdata[0] = 32'h1234;
      push("r5_preload", 32'h1234);
      tick();
      a_wen[0] = 1'b0; a_ridx[0] = 5'd5;
      #1 chk(a_rdata[0]);

      rst = 1'b1;
      repeat (3) tick();
      push("init_rdata_forced0", 0); chk(a_rdata[0]);
      push("init_ready", 0);         chk(32'(a_ready));
      rst = 1'b0;
      push("ready_lat_a2", 32);
      push("ready_lat_b2", 20);
      sweep(1'b1);
      chk(32'(la));
      chk(32'(lb));
      push("r5_swept", 0);           chk(a_rdata[0]);
      a_ridx[1] = 5'd10;
      #1 push("init_rsv_ignored", 0); chk(32'(a_rbusy[1]));

      // Plain write then read
      a_wen[0] = 1'b1; a_widx[0] = 5'd3; a_wdata[0] = 32'hDEADBEEF;
      push("r3_data", 32'hDEADBEEF);
      push("r3_busy", 0);
      tick();
      a_wen[0] = 1'b0; a_ridx[1] = 5'd3;
      #1 chk(a_rdata[1]);
      chk(32'(a_rbusy[1]));

      // Reserve r7, re-reserve flags conflict
      a_rsv_en = 1'b1; a_rsv_idx = 5'd7;
      #1 push("rsv7_first_conflict", 0); chk(32'(a_rsv_conflict));
      tick();
      a_rsv_en = 1'b0; a_ridx[0] = 5'd7;
      #1 push("r7_busy", 1); chk(32'(a_rbusy[0]));
      a_rsv_en = 1'b1;
      #1 push("rsv7_conflict", 1); chk(32'(a_rsv_conflict));
      tick();
      a_rsv_en = 1'b0;

      // Writeback to pending r7
      a_wen[0] = 1'b1; a_widx[0] = 5'd7; a_wdata[0] = 32'h55;
      #1 push("r7_wb_cycle_data", BYP ? 32'h55 : 32'h0); chk(a_rdata[0]);
      push("r7_wb_cycle_busy", BYP ? 0 : 1);            chk(32'(a_rbusy[0]));
      tick();
      a_wen[0] = 1'b0;
      #1 push("r7_after_wb_data", 32'h55); chk(a_rdata[0]);
      push("r7_after_wb_busy", 0);         chk(32'(a_rbusy[0]));

      // Reserve plus clear on the same register: no conflict, set wins
      a_rsv_en = 1'b1; a_rsv_idx = 5'd7;
      tick();
      a_wen[0] = 1'b1; a_widx[0] = 5'd7; a_wdata[0] = 32'h66;
      #1 push("rsv_with_clear_conflict", 0); chk(32'(a_rsv_conflict));
      tick();
      a_wen[0] = 1'b0; a_rsv_en = 1'b0;
      #1 push("r7_set_wins_busy", 1);  chk(32'(a_rbusy[0]));
      push("r7_set_wins_data", 32'h66); chk(a_rdata[0]);

      // Two writers and a reserve on r4
      a_wen[0] = 1'b1; a_widx[0] = 5'd4; a_wdata[0] = 32'hA;
      a_wen[1] = 1'b1; a_widx[1] = 5'd4; a_wdata[1] = 32'hB;
      a_rsv_en = 1'b1; a_rsv_idx = 5'd4;
      tick();
      a_wen[0] = 1'b0; a_wen[1] = 1'b0; a_rsv_en = 1'b0; a_ridx[1] = 5'd4;
      #1 push("r4_collision_data", 32'hB); chk(a_rdata[1]);
      push("r4_collision_busy", 1);        chk(32'(a_rbusy[1]));

      // r0 hardwired
      a_wen[0] = 1'b1; a_widx[0] = 5'd0; a_wdata[0] = 32'hFFFFFFFF;
      a_rsv_en = 1'b1; a_rsv_idx = 5'd0; a_ridx[0] = 5'd0;
      #1 push("r0_rsv_conflict_a", 0); chk(32'(a_rsv_conflict));
      push("r0_write_cycle_data", 0);  chk(a_rdata[0]);
      tick();
      a_wen[0] = 1'b0;
      #1 push("r0_data", 0);           chk(a_rdata[0]);
      push("r0_busy", 0);              chk(32'(a_rbusy[0]));
      push("r0_rsv_conflict_b", 0);    chk(32'(a_rsv_conflict));
      a_rsv_en = 1'b0;

      // Same-cycle write while reading pending r9
      a_rsv_en = 1'b1; a_rsv_idx = 5'd9;
      tick();
      a_rsv_en = 1'b0;
      a_wen[1] = 1'b1; a_widx[1] = 5'd9; a_wdata[1] = 32'h77; a_ridx[0] = 5'd9;
      #1 push("r9_byp_data", BYP ? 32'h77 : 32'h0); chk(a_rdata[0]);
      push("r9_byp_busy", BYP ? 0 : 1);             chk(32'(a_rbusy[0]));
      tick();
      a_wen[1] = 1'b0;
      #1 push("r9_after_data", 32'h77); chk(a_rdata[0]);
      push("r9_after_busy", 0);         chk(32'(a_rbusy[0]));

      // Bypass alongside a same-cycle reserve: busy only from the next cycle
      a_wen[1] = 1'b1; a_wdata[1] = 32'h88; a_rsv_en = 1'b1; a_rsv_idx = 5'd9;
      #1 push("r9_byp_rsv_data", BYP ? 32'h88 : 32'h77); chk(a_rdata[0]);
      push("r9_byp_rsv_busy", 0);                        chk(32'(a_rbusy[0]));
      tick();
      a_wen[1] = 1'b0; a_rsv_en = 1'b0;
      #1 push("r9_next_busy", 1);  chk(32'(a_rbusy[0]));
      push("r9_next_data", 32'h88); chk(a_rdata[0]);

      // Reset in RUN, then again mid-sweep
      rst = 1'b1;
      tick();
      push("rst_run_ready", 0); chk(32'(a_ready));
      rst = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("ready_lat_a3", 32);
      push("ready_lat_b3", 20);
      sweep(1'b0);
      chk(32'(la));
      chk(32'(lb));
      push("r4_pend_cleared", 0); chk(32'(a_rbusy[1]));
      push("r4_data_cleared", 0); chk(a_rdata[1]);

      // Instance B: ordinary r0, out-of-range indices
      b_wen[0] = 1'b1; b_widx[0] = 5'd0; b_wdata[0] = 32'h11;
      tick();
      b_wen[0] = 1'b0; b_ridx[0] = 5'd0;
      #1 push("b_r0_data", 32'h11); chk(b_rdata[0]);
      b_wen[0] = 1'b1; b_widx[0] = 5'd25; b_wdata[0] = 32'h22; b_ridx[1] = 5'd25;
      tick();
      b_wen[0] = 1'b0; b_ridx[0] = 5'd9;
      #1 push("b_oob_data", 0);     chk(b_rdata[1]);
      push("b_no_alias_r9", 0);     chk(b_rdata[0]);
      b_rsv_en = 1'b1; b_rsv_idx = 5'd25;
      tick();
      #1 push("b_oob_conflict", 0); chk(32'(b_rsv_conflict));
      push("b_oob_busy", 0);        chk(32'(b_rbusy[1]));
      b_rsv_idx = 5'd19;
      tick();
      #1 push("b_r19_conflict", 1); chk(32'(b_rsv_conflict));
      b_rsv_en = 1'b0; b_ridx[0] = 5'd19;
      #1 push("b_r19_busy", 1);     chk(32'(b_rbusy[0]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gprf_sb.md
# gprf_sb

Parametrised general-purpose register file with a per-register pending-write scoreboard, a zero-initialisation sweep after reset, and an optional write-to-read bypass. It is the next-generation GPR storage for the core pipeline. Decode reserves a destination register when it issues an instruction. Writeback clears the reservation when it writes the result. Read ports return operand data together with a busy flag that the issue stage uses to stall.

## Interface
Parameters:
- NRPORTS, 2, number of read ports
- NWPORTS, 1, number of write ports
- DEPTH, 32, number of registers
- WIDTH, 32, register width in bits
- R0_IS_0, 0, 1: register 0 reads as 0, and reservations/writes to it are ignored
- IW (localparam), $clog2(DEPTH), index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high once the init sweep is complete
- ridx[0:NRPORTS-1]  in  IW  read index
- rdata[0:NRPORTS-1]  out  WIDTH  read data, combinational
- rbusy[0:NRPORTS-1]  out  1  register at ridx has a pending write
- rsv_en  in  1  reserve (mark pending) register rsv_idx
- rsv_idx  in  IW  register to reserve
- rsv_conflict  out  1  rsv_en targets a register that is already pending and is not cleared this cycle
- wen[0:NWPORTS-1]  in  1  write enable
- widx[0:NWPORTS-1]  in  IW  write index
- wdata[0:NWPORTS-1]  in  WIDTH  write data

## Operation
- The FSM has two states: INIT and RUN.
- rst=1 forces INIT on the next edge:
  - sweep counter := 0
  - all pending bits := 0
- INIT:
  - Each cycle writes 0 to array[cnt], then cnt increments.
  - When cnt == DEPTH-1, the FSM moves to RUN on that edge.
  - wen and rsv_en are ignored.
  - rdata = 0, rbusy = 0, rsv_conflict = 0, ready = 0.
- RUN:
  - ready = 1.
  - Write port wp with wen[wp] writes wdata[wp] to array[widx[wp]] and clears pend[widx[wp]].
  - If several ports write the same index in one cycle, the highest-numbered active port wins.
  - rsv_en sets pend[rsv_idx].
  - If a reserve and a write hit the same index in one cycle, the set wins: the new producer remains pending. The write data is still stored.
- Read port rp, with no bypass:
  - rdata[rp] = array[ridx[rp]]
  - rbusy[rp] = pend[ridx[rp]]
- R0_IS_0=1:
  - ridx==0 gives rdata=0 and rbusy=0.
  - Writes and reservations to index 0 are dropped.
  - pend[0] is held at 0.
- rsv_conflict = rsv_en & pend[rsv_idx] & ~(some wen clears rsv_idx this cycle). It is only a flag; the reservation still takes effect.
- Indices ≥ DEPTH (non-power-of-2 DEPTH) are ignored on write and reserve, and read as 0 and not busy.

## Timing
- Reset values:
  - ready = 0
  - rbusy = 0
  - rsv_conflict = 0
  - rdata = 0
- ready rises exactly DEPTH cycles after the first edge with rst=0.
- Write latency is 1 cycle: a read in the cycle after the write edge returns the new value.
- Scoreboard latency is 1 cycle: rbusy reflects a reserve or clear from the next cycle.
- Asserting rst mid-sweep or in RUN restarts the sweep from entry 0. It clears all pending bits in the same edge.

## Configuration
- GPRF_SB_BYPASS_EN defined:
  - In RUN, if any wen[wp] matches ridx[rp] (and the index is non-zero when R0_IS_0), rdata[rp] = the winning wdata and rbusy[rp] = 0 in the same cycle.
  - A same-cycle reserve of that index does not reassert rbusy until the next cycle.
- GPRF_SB_BYPASS_EN undefined: reads see only the registered array and pend state. There are no combinational paths from wen, widx or wdata to rdata or rbusy.

## Structure
- Package gprf_pkg holds:
  - the state enum (GPRF_INIT, GPRF_RUN)
  - default DEPTH/WIDTH constants
- The sub-module gprf_scoreboard holds the DEPTH pending bits. It has:
  - a reserve port and NWPORTS clear ports
  - NRPORTS busy lookups and the conflict output
  - the same reset and R0 rules as above
- Data array, sweep counter, FSM and bypass muxing live in gprf_sb.

## Test plan
- Reset sweep: rst high for 3 cycles, then low; preload r5 = 0x1234 before reset → ready=0 for 32 cycles, then 1; r5 reads 0x00000000.
- Write/read (RUN): wen[0], widx=3, wdata=0xDEADBEEF → the next cycle, ridx=3 returns 0xDEADBEEF with rbusy=0.
- Scoreboard: rsv_en on r7 → rbusy=1 the next cycle; write r7=0x55 → rbusy=0 and rdata=0x55 the next cycle. A second rsv on pending r7 gives rsv_conflict=1.
- Write collision (NWPORTS=2): both ports write r4 (0xA, 0xB) → r4 reads 0xB; a same-cycle rsv on r4 leaves rbusy=1.
- R0_IS_0=1: write r0=0xFFFFFFFF and rsv r0 → r0 reads 0, rbusy=0, rsv_conflict stays 0.
- Bypass (macro defined): pend r9, then write r9=0x77 while ridx=9 → rdata=0x77 and rbusy=0 in the same cycle. With the macro undefined → old value and rbusy=1 that cycle.
